usb_tx_encoder: RTL and testbench
=================================

# usb_tx_encoder

USB full-speed transmit encoder: on command, emits one complete packet on the bus:
- SYNC, PID, payload, CRC16 and EOP, bit-stuffed and NRZI-encoded on `dp_out`/`dm_out`.
- Downstream consumer of `fifo_data_buffer`: pops payload bytes via `get_tx_packet_data`/`tx_packet_data` and sizes the payload from `buffer_occupancy`.
- Driven by the protocol controller through `tx_start`/`tx_packet`.

## Interface
- `CLKS_PER_BIT`, 4 — clk cycles per USB bit time (48 MHz clk / 12 Mb/s); legal ≥ 4.
- `clk` in 1 — system clock; all logic rising-edge.
- `rst` in 1 — reset, synchronous, active-high.
- `tx_start` in 1 — one-cycle request; sampled only in IDLE.
- `tx_packet` in 3 — packet code, sampled with `tx_start`:
  - 1 = DATA0, 2 = DATA1, 3 = ACK, 4 = NAK, 5 = STALL.
  - Any other code is invalid.
- `tx_packet_data` in 8 — byte at the buffer head; valid the cycle after `get_tx_packet_data`.
- `buffer_occupancy` in 7 — payload byte count (0..64).
- `get_tx_packet_data` out 1 — one-cycle pop strobe to the buffer.
- `tx_transfer_active` out 1 — high from the cycle after an accepted `tx_start` through the last EOP J bit.
- `tx_done` out 1 — one-cycle pulse after the EOP J bit completes.
- `tx_error` out 1 — one-cycle pulse on a rejected request.
- `dp_out`, `dm_out` out 1 each — registered bus levels. J = 1/0, K = 0/1, SE0 = 0/0.

## Operation
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J.
- IDLE:
  - On `tx_start` with a valid code, latch the code and `buffer_occupancy` into the 7-bit `bytes_left`, then go to SYNC.
  - On an invalid code, or a data PID with latched occupancy > 64, pulse `tx_error` and stay in IDLE with the bus idle (J).
- Bit order: every field is sent LSB first.
  - SYNC = 0x80.
  - PID byte = {~pid[3:0], pid[3:0]}: DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
- Routing after PID:
  - ACK/NAK/STALL go PID → EOP_SE0.
  - Data PIDs go PID → DATA while `bytes_left` ≠ 0; otherwise PID → CRC_LO.
- DATA:
  - Each byte decrements `bytes_left`.
  - When the last bit of a byte is sent, go to CRC_LO if `bytes_left` = 0, else load the next byte.
- CRC16:
  - Polynomial 0x8005, init 0xFFFF, updated on payload bits only (pre-stuffing), LSB first.
  - Transmitted as the ones-complement of the register: low byte (CRC_LO), then high byte (CRC_HI).
- Bit stuffing:
  - A 3-bit ones-run counter spans SYNC through CRC_HI.
  - After six consecutive logical 1s, insert one extra 0 bit time. The field bit counter does not advance during the insertion; the run resets to 0.
- NRZI: logical 0 toggles J↔K; logical 1 holds. The line is J entering SYNC.
- EOP: two bit times of SE0 (EOP_SE0), then one bit time of J (EOP_J), then IDLE. No stuffing, no NRZI.
- `tx_start` while not in IDLE is ignored: no error, no effect.
- Arithmetic widths:
  - Bit-time counter: $clog2(`CLKS_PER_BIT`).
  - Bit index: 3 bits.
  - `bytes_left`: 7 bits; never decrements below 0.

## Timing
- Reset values: `dp_out`=1, `dm_out`=0, all other outputs 0, state IDLE, CRC register 0xFFFF, stuff run 0.
- `rst` mid-packet: the next edge forces the reset values and abandons the packet. No `tx_done`, no further pops.
- Latency: the first SYNC bit appears on `dp_out`/`dm_out` at the edge after `tx_start` is sampled. Each bit is held exactly `CLKS_PER_BIT` clocks.
- Byte fetch:
  - `get_tx_packet_data` pulses for one clk in the first cycle of the final bit time of the preceding field byte (PID or previous data byte).
  - `tx_packet_data` is captured on the following edge.
  - Exactly N pops per N-byte payload; zero pops for handshakes.
- Packet length in bit times = 8 + 8 + 8N + 16·(data PID) + stuffed bits + 3.
- `tx_done` is asserted in the cycle after the final EOP J clock. `tx_transfer_active` falls in that same cycle.

## Configuration
- `USB_TX_ZLP_EN`:
  - Defined: a data PID with `buffer_occupancy` = 0 sends a zero-length packet (PID, CRC 0x0000, EOP).
  - Undefined: that request pulses `tx_error` and sends nothing.

## Test plan
- ACK, `CLKS_PER_BIT`=4 → bus sequence per bit time:
  - SYNC: KJKJKJKK.
  - PID 0xD2: bits 0,1,0,0,1,0,1,1.
  - EOP: SE0, SE0, J.
  - Result: 19 bit times = 76 clks, zero pops, one `tx_done`.
- DATA0, occupancy 1, byte 0xFF:
  - PID ends in "11", so a stuffed 0 is inserted after the 4th data bit.
  - Exactly 1 pop; CRC transmitted matches the 0x8005 model.
  - 8+8+8+1+16+3 = 44 bit times, plus any CRC-field stuffing per the model.
- DATA1, occupancy 0:
  - With `USB_TX_ZLP_EN`: CRC field = 16 zeros (16 NRZI toggles).
  - Without it: `tx_error` pulse, bus held at J.
- `tx_packet`=7, or DATA0 with occupancy 65 → one-cycle `tx_error`, `dp_out`/`dm_out` stay 1/0, `tx_transfer_active` stays 0.
- DATA0, 64 bytes 0x01..0x40 → exactly 64 pops, with bytes appearing in order on the bus; second `tx_start` mid-packet ignored.
- `rst` asserted during DATA of a 17-byte packet → next edge `dp_out`=1, `dm_out`=0, `tx_transfer_active`=0, no `tx_done`.

Source files
------------

// File: rtl/usb_tx_encoder_if.sv
// Buffer/controller-facing signal bundle of the USB full-speed transmit encoder.
// master = controller/buffer side, slave = encoder side.
interface usb_tx_encoder_if;
   logic       tx_start;
   logic [2:0] tx_packet;
   logic [7:0] tx_packet_data;
   logic [6:0] buffer_occupancy;
   logic       get_tx_packet_data;
   logic       tx_transfer_active;
   logic       tx_done;
   logic       tx_error;
   logic       dp_out;
   logic       dm_out;

   modport master (
      output tx_start, tx_packet, tx_packet_data, buffer_occupancy,
      input  get_tx_packet_data, tx_transfer_active, tx_done, tx_error, dp_out, dm_out
   );

   modport slave (
      input  tx_start, tx_packet, tx_packet_data, buffer_occupancy,
      output get_tx_packet_data, tx_transfer_active, tx_done, tx_error, dp_out, dm_out
   );
endinterface

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC, PID, payload, CRC16, EOP with bit stuffing and NRZI.
// Optional USB_TX_ZLP_EN: data PID with zero occupancy sends a zero-length packet instead of an error.
module usb_tx_encoder #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input logic             clk,
   input logic             rst,
   usb_tx_encoder_if.slave bus
);
   localparam int unsigned CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [6:0]  MAX_BYTES = 7'd64;
   localparam logic [15:0] CRC_INIT  = 16'hFFFF;
   localparam logic [15:0] CRC_POLY  = 16'hA001;  // 0x8005 bit-reversed for LSB-first shifting
`ifdef USB_TX_ZLP_EN
   localparam bit ZLP_EN = 1'b1;
`else
   localparam bit ZLP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic [3:0]       pid, pid_nxt;
   logic [6:0]       bytes_left, bytes_left_nxt;
   logic [15:0]      crc, crc_nxt;
   logic [2:0]       run, run_nxt;
   logic             line, line_nxt;
   logic             dp, dp_nxt, dm, dm_nxt;
   logic             get, get_nxt, done, done_nxt, err, err_nxt, active, active_nxt;
   logic             get_d;
   logic [7:0]       nxt_byte;

   logic             bit_end, data_pid, load_en, load_val, load_stuff;
   logic [3:0]       req_code;
   logic             req_valid, req_data, req_bad;

   assign bit_end  = (clk_cnt == CNT_LAST);
   assign data_pid = (pid[1:0] == 2'b11);

   // Packet code to PID nibble
   always_comb begin
      req_valid = 1'b1;
      case (bus.tx_packet)
         3'd1:    req_code = 4'h3;
         3'd2:    req_code = 4'hB;
         3'd3:    req_code = 4'h2;
         3'd4:    req_code = 4'hA;
         3'd5:    req_code = 4'hE;
         default: begin req_code = 4'h0; req_valid = 1'b0; end
      endcase
   end

   assign req_data = (req_code[1:0] == 2'b11);
   assign req_bad  = !req_valid ||
                     (req_data && ((bus.buffer_occupancy > MAX_BYTES) ||
                                   (bus.buffer_occupancy == 7'd0 && !ZLP_EN)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;   clk_cnt <= '0;   bit_idx <= 3'd0;  shreg <= 8'h00;
         pid <= 4'h0;     bytes_left <= 7'd0; crc <= CRC_INIT; run <= 3'd0;
         line <= 1'b1;    dp <= 1'b1;      dm <= 1'b0;
         get <= 1'b0;     done <= 1'b0;    err <= 1'b0;      active <= 1'b0;
         get_d <= 1'b0;   nxt_byte <= 8'h00;
      end else begin
         state <= state_nxt; clk_cnt <= clk_cnt_nxt; bit_idx <= bit_idx_nxt; shreg <= shreg_nxt;
         pid <= pid_nxt;     bytes_left <= bytes_left_nxt; crc <= crc_nxt; run <= run_nxt;
         line <= line_nxt;   dp <= dp_nxt;   dm <= dm_nxt;
         get <= get_nxt;     done <= done_nxt; err <= err_nxt; active <= active_nxt;
         get_d <= get;
         // Buffer presents the popped byte the cycle after the strobe
         if (get_d) nxt_byte <= bus.tx_packet_data;
      end
   end

   always_comb begin
      state_nxt = state;  bit_idx_nxt = bit_idx;  shreg_nxt = shreg;  pid_nxt = pid;
      bytes_left_nxt = bytes_left;  crc_nxt = crc;  run_nxt = run;  line_nxt = line;
      active_nxt = active;  get_nxt = 1'b0;  done_nxt = 1'b0;  err_nxt = 1'b0;
      clk_cnt_nxt = (state == IDLE || bit_end) ? '0 : clk_cnt + CNT_W'(1);
      load_en = 1'b0;  load_val = 1'b0;  load_stuff = 1'b0;

      case (state)
         IDLE: begin
            if (bus.tx_start) begin
               if (req_bad) begin
                  err_nxt = 1'b1;
               end else begin
                  state_nxt      = SYNC;
                  pid_nxt        = req_code;
                  bytes_left_nxt = bus.buffer_occupancy;
                  crc_nxt        = CRC_INIT;
                  run_nxt        = 3'd0;
                  bit_idx_nxt    = 3'd0;
                  shreg_nxt      = 8'h80;
                  active_nxt     = 1'b1;
                  load_en        = 1'b1;
               end
            end
         end
         SYNC, PID, DATA, CRC_LO, CRC_HI: begin
            if (bit_end) begin
               if (run == 3'd6) begin
                  load_en = 1'b1;  load_stuff = 1'b1;
               end else if (bit_idx != 3'd7) begin
                  bit_idx_nxt = bit_idx + 3'd1;
                  load_en     = 1'b1;
                  load_val    = shreg[bit_idx + 3'd1];
               end else begin
                  bit_idx_nxt = 3'd0;
                  load_en     = 1'b1;
                  case (state)
                     SYNC: begin state_nxt = PID; shreg_nxt = {~pid, pid}; end
                     PID, DATA: begin
                        if (state == PID && !data_pid) begin
                           state_nxt = EOP_SE0;
                        end else if (bytes_left != 7'd0) begin
                           state_nxt      = DATA;
                           shreg_nxt      = nxt_byte;
                           bytes_left_nxt = bytes_left - 7'd1;
                        end else begin
                           state_nxt = CRC_LO;
                           shreg_nxt = ~crc[7:0];
                        end
                     end
                     CRC_LO:  begin state_nxt = CRC_HI; shreg_nxt = ~crc[15:8]; end
                     default: state_nxt = EOP_SE0;
                  endcase
                  load_val = shreg_nxt[0];
                  if (state_nxt == EOP_SE0) begin
                     load_en  = 1'b0;
                     line_nxt = 1'b1;
                     run_nxt  = 3'd0;
                  end
               end
            end
         end
         EOP_SE0: begin
            if (bit_end) begin
               if (bit_idx == 3'd1) begin
                  state_nxt   = EOP_J;
                  bit_idx_nxt = 3'd0;
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
               end
            end
         end
         EOP_J: begin
            if (bit_end) begin
               state_nxt  = IDLE;
               done_nxt   = 1'b1;
               active_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // NRZI, stuff run and CRC all advance when a new bit goes onto the line
      if (load_en) begin
         line_nxt = load_val ? line : ~line;
         run_nxt  = load_val ? run + 3'd1 : 3'd0;
         if (state_nxt == DATA && !load_stuff)
            crc_nxt = {1'b0, crc[15:1]} ^ ((crc[0] ^ load_val) ? CRC_POLY : 16'h0000);
      end

      get_nxt = load_en && !load_stuff && (bit_idx_nxt == 3'd7) && (bytes_left != 7'd0) &&
                (state_nxt == DATA || (state_nxt == PID && data_pid));
      dp_nxt  = (state_nxt == EOP_SE0) ? 1'b0 : line_nxt;
      dm_nxt  = (state_nxt == EOP_SE0) ? 1'b0 : ~line_nxt;
   end

   assign bus.get_tx_packet_data = get;
   assign bus.tx_transfer_active = active;
   assign bus.tx_done            = done;
   assign bus.tx_error           = err;
   assign bus.dp_out             = dp;
   assign bus.dm_out             = dm;
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: randomized packets against a bit-level packet model
// (field assembly, byte-wise CRC16, stuffing, NRZI) compared clock by clock on the bus.
module tb_usb_tx_encoder;
   localparam int unsigned CPB = 4;
   localparam logic [1:0] SYM_J = 2'b10, SYM_K = 2'b01, SYM_SE0 = 2'b00;

   logic clk, rst;
   usb_tx_encoder_if bus();
   usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0;
   logic [7:0] pay [0:127];
   logic [1:0] obs[$], exp_q[$];
   int   obs_pops, first_pop, obs_err, obs_done_early;
   logic done_now, done_next, err_now, err_next;
   logic [1:0] bus_now;
   logic timed_out;

   // Drives one request, serves buffer pops, and records the bus per clock while active
   task automatic drive_packet(input logic [2:0] code, input logic [6:0] occ, input int inject_at);
      int rd = 0;
      obs.delete(); obs_pops = 0; first_pop = -1; obs_err = 0; obs_done_early = 0;
      @(negedge clk);
      bus.tx_packet = code; bus.buffer_occupancy = occ; bus.tx_start = 1'b1;
      @(negedge clk);
      bus.tx_start = 1'b0;
      for (int c = 0; c < 5000 && bus.tx_transfer_active; c++) begin
         if (bus.tx_error) obs_err++;
         if (bus.tx_done) obs_done_early++;
         obs.push_back({bus.dp_out, bus.dm_out});
         if (bus.get_tx_packet_data) begin
            if (first_pop < 0) first_pop = obs.size() - 1;
            bus.tx_packet_data = pay[rd % 128];
            rd++; obs_pops++;
         end
         bus.tx_start = (int'(obs.size()) - 1 == inject_at);
         if (bus.tx_start) bus.tx_packet = 3'd3;
         @(negedge clk);
      end
      bus.tx_start = 1'b0;
      timed_out = bus.tx_transfer_active;
      done_now  = bus.tx_done; err_now = bus.tx_error; bus_now = {bus.dp_out, bus.dm_out};
      @(negedge clk);
      done_next = bus.tx_done; err_next = bus.tx_error;
   endtask

   // Expected per-clock bus symbols for a packet built from pay[0..n-1]
   task automatic build_exp(input logic [2:0] code, input int n);
      logic [7:0] pidb, sync_b, d;
      logic [15:0] crc;
      bit raw[$], st[$];
      int run;
      logic [1:0] lvl;
      sync_b = 8'h80;
      case (code)
         3'd1: pidb = 8'hC3;  3'd2: pidb = 8'h4B;  3'd3: pidb = 8'hD2;
         3'd4: pidb = 8'h5A;  3'd5: pidb = 8'h1E;  default: pidb = 8'h00;
      endcase
      for (int i = 0; i < 8; i++) raw.push_back(sync_b[i]);
      for (int i = 0; i < 8; i++) raw.push_back(pidb[i]);
      if (code == 3'd1 || code == 3'd2) begin
         crc = 16'hFFFF;
         for (int k = 0; k < n; k++) begin
            d = pay[k];
            for (int i = 0; i < 8; i++) raw.push_back(d[i]);
            crc = crc ^ {8'h00, d};
            for (int j = 0; j < 8; j++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
         end
         crc = ~crc;
         for (int i = 0; i < 16; i++) raw.push_back(crc[i]);
      end
      run = 0;
      foreach (raw[i]) begin
         st.push_back(raw[i]);
         run = raw[i] ? run + 1 : 0;
         if (run == 6) begin st.push_back(1'b0); run = 0; end
      end
      exp_q.delete();
      lvl = SYM_J;
      foreach (st[i]) begin
         if (!st[i]) lvl = (lvl == SYM_J) ? SYM_K : SYM_J;
         repeat (CPB) exp_q.push_back(lvl);
      end
      repeat (2 * CPB) exp_q.push_back(SYM_SE0);
      repeat (CPB) exp_q.push_back(SYM_J);
   endtask

   function automatic int seq_diff();
      int m = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
      for (int i = 0; i < m; i++) if (obs[i] !== exp_q[i]) return i;
      if (obs.size() != exp_q.size()) return m;
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1; bus.tx_start = 1'b0; bus.tx_packet = 3'd0;
      bus.tx_packet_data = 8'h00; bus.buffer_occupancy = 7'd0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.dp_out, bus.dm_out} !== SYM_J) begin
         n_fail++; $display("FAIL reset_bus: got %b, expected %b", {bus.dp_out, bus.dm_out}, SYM_J);
      end
      n_checks++;
      if ({bus.tx_transfer_active, bus.tx_done, bus.tx_error, bus.get_tx_packet_data} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_outs: got %b, expected 0000",
            {bus.tx_transfer_active, bus.tx_done, bus.tx_error, bus.get_tx_packet_data});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus.dp_out, bus.dm_out, bus.tx_transfer_active} !== 3'b100) begin
         n_fail++; $display("FAIL idle_after_reset: got %b, expected 100",
            {bus.dp_out, bus.dm_out, bus.tx_transfer_active});
      end
   endtask

   task automatic test_ack();
      logic [15:0] sync_obs;
      build_exp(3'd3, 0);
      drive_packet(3'd3, 7'd0, -1);
      n_checks++;
      if (seq_diff() !== -1) begin
         n_fail++; $display("FAIL ack_bus: differs at clk %0d, got %0d clks, expected %0d", seq_diff(), obs.size(), exp_q.size());
      end
      n_checks++;
      if (obs.size() !== 76) begin n_fail++; $display("FAIL ack_len: got %0d, expected 76", obs.size()); end
      sync_obs = 16'h0;
      for (int i = 0; i < 8 && i * CPB < obs.size(); i++) sync_obs[15 - 2*i -: 2] = obs[i * CPB];
      n_checks++;
      if (sync_obs !== {SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_K}) begin
         n_fail++; $display("FAIL ack_sync: got %h, expected %h", sync_obs, {SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_K});
      end
      n_checks++;
      if ({obs_pops, obs_err, obs_done_early} !== {32'd0, 32'd0, 32'd0}) begin
         n_fail++; $display("FAIL ack_pops: got pops=%0d err=%0d early_done=%0d, expected 0/0/0", obs_pops, obs_err, obs_done_early);
      end
      n_checks++;
      if ({done_now, done_next} !== 2'b10) begin n_fail++; $display("FAIL ack_done: got %b, expected 10", {done_now, done_next}); end
   endtask

   task automatic test_handshakes();
      for (int k = 0; k < 4; k++) begin
         logic [2:0] code = (k % 2 == 0) ? 3'd4 : 3'd5;
         logic [6:0] occ  = 7'($urandom_range(0, 127));
         build_exp(code, 0);
         drive_packet(code, occ, -1);
         n_checks++;
         if (seq_diff() !== -1 || obs_pops !== 0 || {done_now, done_next} !== 2'b10) begin
            n_fail++; $display("FAIL handshake_%0d: diff@%0d pops=%0d done=%b, expected diff@-1 pops=0 done=10",
               code, seq_diff(), obs_pops, {done_now, done_next});
         end
      end
   endtask

   task automatic test_data_ff();
      pay[0] = 8'hFF;
      build_exp(3'd1, 1);
      drive_packet(3'd1, 7'd1, -1);
      n_checks++;
      if (seq_diff() !== -1) begin
         n_fail++; $display("FAIL ff_bus: differs at clk %0d, got %0d clks, expected %0d", seq_diff(), obs.size(), exp_q.size());
      end
      n_checks++;
      if (obs_pops !== 1 || first_pop !== 15 * CPB) begin
         n_fail++; $display("FAIL ff_pop: got pops=%0d at clk %0d, expected 1 at clk %0d", obs_pops, first_pop, 15 * CPB);
      end
      n_checks++;
      if (obs.size() < 22 * CPB || obs[20*CPB] === obs[19*CPB] || obs[21*CPB] !== obs[20*CPB]) begin
         n_fail++; $display("FAIL ff_stuff: got bit19..21 %b %b %b, expected hold-toggle-hold",
            (obs.size() > 19*CPB) ? obs[19*CPB] : 2'bxx, (obs.size() > 20*CPB) ? obs[20*CPB] : 2'bxx,
            (obs.size() > 21*CPB) ? obs[21*CPB] : 2'bxx);
      end
      n_checks++;
      if ({done_now, done_next} !== 2'b10) begin n_fail++; $display("FAIL ff_done: got %b, expected 10", {done_now, done_next}); end
   endtask

   task automatic test_random_data();
      for (int k = 0; k < 8; k++) begin
         logic [2:0] code = 3'($urandom_range(1, 2));
         int n = $urandom_range(1, 24);
         for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
         build_exp(code, n);
         drive_packet(code, 7'(n), -1);
         n_checks++;
         if (seq_diff() !== -1 || obs_pops !== n || obs_err !== 0 || {done_now, done_next} !== 2'b10 || timed_out !== 1'b0) begin
            n_fail++; $display("FAIL rand_data_%0d: diff@%0d pops=%0d err=%0d done=%b to=%b, expected diff@-1 pops=%0d err=0 done=10 to=0",
               k, seq_diff(), obs_pops, obs_err, {done_now, done_next}, timed_out, n);
         end
      end
   endtask

   task automatic test_zlp();
`ifdef USB_TX_ZLP_EN
      build_exp(3'd2, 0);
      drive_packet(3'd2, 7'd0, -1);
      n_checks++;
      if (seq_diff() !== -1 || obs_pops !== 0 || {done_now, done_next} !== 2'b10) begin
         n_fail++; $display("FAIL zlp_packet: diff@%0d pops=%0d done=%b, expected diff@-1 pops=0 done=10",
            seq_diff(), obs_pops, {done_now, done_next});
      end
`else
      drive_packet(3'd2, 7'd0, -1);
      n_checks++;
      if ({err_now, err_next} !== 2'b10 || obs.size() !== 0 || bus_now !== SYM_J) begin
         n_fail++; $display("FAIL zlp_reject: err=%b clks=%0d bus=%b, expected err=10 clks=0 bus=%b",
            {err_now, err_next}, obs.size(), bus_now, SYM_J);
      end
`endif
   endtask

   task automatic test_errors();
      logic [2:0] codes [5] = '{3'd0, 3'd6, 3'd7, 3'd1, 3'd2};
      logic [6:0] occs  [5] = '{7'd5, 7'd5, 7'd5, 7'd65, 7'd127};
      for (int k = 0; k < 5; k++) begin
         drive_packet(codes[k], occs[k], -1);
         n_checks++;
         if ({err_now, err_next} !== 2'b10 || obs.size() !== 0 || bus_now !== SYM_J || done_now !== 1'b0) begin
            n_fail++; $display("FAIL error_%0d: err=%b active_clks=%0d bus=%b done=%b, expected err=10 active_clks=0 bus=%b done=0",
               k, {err_now, err_next}, obs.size(), bus_now, done_now, SYM_J);
         end
      end
   endtask

   task automatic test_max_64();
      for (int i = 0; i < 64; i++) pay[i] = 8'(i + 1);
      build_exp(3'd1, 64);
      drive_packet(3'd1, 7'd64, 400);
      n_checks++;
      if (seq_diff() !== -1) begin
         n_fail++; $display("FAIL max64_bus: differs at clk %0d, got %0d clks, expected %0d", seq_diff(), obs.size(), exp_q.size());
      end
      n_checks++;
      if (obs_pops !== 64 || obs_err !== 0) begin
         n_fail++; $display("FAIL max64_pops: got pops=%0d err=%0d, expected 64/0", obs_pops, obs_err);
      end
      n_checks++;
      if ({done_now, done_next} !== 2'b10) begin n_fail++; $display("FAIL max64_done: got %b, expected 10", {done_now, done_next}); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) begin
         logic [2:0] code = 3'($urandom_range(1, 5));
         int n = (code <= 3'd2) ? $urandom_range(1, 8) : 0;
         for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
         build_exp(code, n);
         drive_packet(code, 7'(n), -1);
         n_checks++;
         if (seq_diff() !== -1 || obs_pops !== n || {done_now, done_next} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_%0d: diff@%0d pops=%0d done=%b, expected diff@-1 pops=%0d done=10",
               k, seq_diff(), obs_pops, {done_now, done_next}, n);
         end
      end
   endtask

   task automatic test_reset_mid();
      int dones = 0, gets = 0, moves = 0;
      for (int i = 0; i < 17; i++) pay[i] = 8'($urandom);
      @(negedge clk);
      bus.tx_packet = 3'd1; bus.buffer_occupancy = 7'd17; bus.tx_start = 1'b1;
      @(negedge clk);
      bus.tx_start = 1'b0;
      repeat (300) @(negedge clk);
      n_checks++;
      if (bus.tx_transfer_active !== 1'b1) begin n_fail++; $display("FAIL rstmid_active: got %b, expected 1", bus.tx_transfer_active); end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.dp_out, bus.dm_out, bus.tx_transfer_active, bus.tx_done, bus.get_tx_packet_data} !== 5'b10000) begin
         n_fail++; $display("FAIL rstmid_force: got %b, expected 10000",
            {bus.dp_out, bus.dm_out, bus.tx_transfer_active, bus.tx_done, bus.get_tx_packet_data});
      end
      rst = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (bus.tx_done) dones++;
         if (bus.get_tx_packet_data) gets++;
         if ({bus.dp_out, bus.dm_out} !== SYM_J) moves++;
      end
      n_checks++;
      if (dones !== 0 || gets !== 0 || moves !== 0) begin
         n_fail++; $display("FAIL rstmid_quiet: got done=%0d pops=%0d bus_moves=%0d, expected 0/0/0", dones, gets, moves);
      end
      build_exp(3'd3, 0);
      drive_packet(3'd3, 7'd0, -1);
      n_checks++;
      if (seq_diff() !== -1) begin n_fail++; $display("FAIL rstmid_recover: differs at clk %0d, expected none", seq_diff()); end
   endtask

   initial begin
      test_reset();
      test_ack();
      test_handshakes();
      test_data_ff();
      test_random_data();
      test_zlp();
      test_errors();
      test_max_64();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
